telem_frame_mon: RTL

TELEM_FRAME_MON -- requirements
Module: telem_frame_mon

---
 rtl/telem_pkg.sv | 18 +
 rtl/telem_tmo_cnt.sv | 30 +++
 rtl/telem_frame_mon.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/telem_pkg.sv
// Shared types and constants for the telemetry frame monitor.
// Imported by the monitor top and its timeout counter.
package telem_pkg;

  localparam int CHAN_W = 12;

  localparam logic [7:0] HDR0_DEF = 8'hAA;
  localparam logic [7:0] HDR1_DEF = 8'h55;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HI,
    ST_LO,
    ST_CHK
  } state_t;

endpackage

// File: rtl/telem_tmo_cnt.sv
// Inter-byte timeout counter: clears on clr, counts while en,
// saturates at TMO_CYC and flags expired while it sits there.
module telem_tmo_cnt #(
  parameter int TMO_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] LIM = CW'(TMO_CYC);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LIM) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == LIM);

endmodule

// File: rtl/telem_frame_mon.sv
// Telemetry frame monitor: parses sync/payload/checksum bytes from
// a UART receiver and publishes the last good frame atomically.
module telem_frame_mon
  import telem_pkg::*;
#(
  parameter int         NUM_CH  = 3,
  parameter logic [7:0] HDR0    = HDR0_DEF,
  parameter logic [7:0] HDR1    = HDR1_DEF,
  parameter bit         CHK_EN  = 1'b1,
  parameter int         TMO_CYC = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_rdy,
  input  logic [7:0]               rx_data,
  output logic                     clr_rdy,
  output logic [NUM_CH*CHAN_W-1:0] ch_data,
  output logic                     frame_vld,
  output logic                     frame_err,
  output logic [15:0]              frame_cnt,
  output logic [7:0]               err_cnt
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_CH - 1);
  localparam int DW = NUM_CH * CHAN_W;

  state_t         state;
  state_t         state_nx;
  logic [IW-1:0]  idx;
  logic [7:0]     chk;
  logic [3:0]     hi_nib;
  logic [DW-1:0]  shadow;
  logic [DW-1:0]  shadow_nx;

  logic commit;
  logic abort;
  logic ld_sync;
  logic ld_hi;
  logic ld_lo;
  logic tmo_en;
  logic tmo_clr;
  logic tmo;

  assign clr_rdy = rx_rdy;

  telem_tmo_cnt #(
    .TMO_CYC(TMO_CYC)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (commit || abort) begin
      state_nx = ST_IDLE;
    end else if (rx_rdy) begin
      unique case (state)
        ST_IDLE: if (rx_data == HDR0) state_nx = ST_SYNC;
        ST_SYNC: if (rx_data == HDR1) state_nx = ST_HI;
        ST_HI:   state_nx = ST_LO;
        ST_LO:   state_nx = (idx == LAST) ? ST_CHK : ST_HI;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // A byte always wins over a coincident timeout.
  always_comb begin
    commit  = 1'b0;
    abort   = 1'b0;
    tmo_en  = (state != ST_IDLE);
    tmo_clr = rx_rdy || (state == ST_IDLE);
    ld_sync = rx_rdy && (state == ST_SYNC) && (rx_data == HDR1);
    ld_hi   = rx_rdy && (state == ST_HI) && (rx_data[7:4] == 4'h0);
    ld_lo   = rx_rdy && (state == ST_LO);
    if (rx_rdy) begin
      unique case (state)
        ST_SYNC: abort = (rx_data != HDR1) && (rx_data != HDR0);
        ST_HI:   abort = (rx_data[7:4] != 4'h0);
        ST_LO:   commit = (idx == LAST) && !CHK_EN;
        ST_CHK: begin
          commit = (rx_data == chk);
          abort  = (rx_data != chk);
        end
        default: ;
      endcase
    end else begin
      abort = tmo;
    end
  end

  always_comb begin
    shadow_nx = shadow;
    if (ld_lo) shadow_nx[idx*CHAN_W +: CHAN_W] = {hi_nib, rx_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      chk       <= '0;
      hi_nib    <= '0;
      shadow    <= '0;
      ch_data   <= '0;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      frame_vld <= commit;
      frame_err <= abort;
      shadow    <= shadow_nx;
      if (ld_sync) begin
        idx <= '0;
        chk <= '0;
      end
      if (ld_hi) begin
        hi_nib <= rx_data[3:0];
        chk    <= chk ^ rx_data;
      end
      if (ld_lo) begin
        chk <= chk ^ rx_data;
        if (idx != LAST) idx <= idx + 1'b1;
      end
      if (commit) begin
        ch_data <= shadow_nx;
        if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 1'b1;
      end
      if (abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
